// File: rtl/int_mem_pkg.sv
// int_mem_pkg: shared types, default clear word and depth helper for int_mem_param
package int_mem_pkg;
  typedef enum logic {CLEAR, READY} state_t;
  localparam logic [7:0] CLR_VAL_DEF = 8'h00;
  function automatic int depth_of(input int aw);
    return 1 << aw;
  endfunction
endpackage

// File: rtl/int_mem_clr_seq.sv
// int_mem_clr_seq: clear sequencer FSM driving one array word per cycle after reset or clr_req
module int_mem_clr_seq
  import int_mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic [DATA_W-1:0] clr_data,
  output logic              init_busy,
  output logic              init_done
);
  state_t state;
  logic [ADDR_W-1:0] clr_ptr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLEAR;
      clr_ptr   <= '0;
      init_done <= 1'b0;
    end else if (state == CLEAR) begin
      clr_ptr <= clr_ptr + 1'b1;
      if (clr_ptr == '1) begin
        state     <= READY;
        init_done <= 1'b1;
      end
    end else if (clr_req) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end
  end
  assign init_busy = (state == CLEAR);
  assign clr_we    = init_busy;
  assign clr_addr  = clr_ptr;
  assign clr_data  = CLR_VAL;
endmodule

// File: rtl/int_mem_param.sv
// int_mem_param: parametrised 8051 internal RAM with clear sequencer and selectable read path
module int_mem_param
  import int_mem_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int READ_MODE = 0,
  parameter logic [DATA_W-1:0] CLR_VAL = DATA_W'(CLR_VAL_DEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              we1_n,
  input  logic              we2_n,
  input  logic              rd_n,
  input  logic              clr_req,
  output logic [DATA_W-1:0] data_out,
  output logic              init_busy,
  output logic              init_done
);
  localparam int DEPTH = depth_of(ADDR_W);
  logic [DATA_W-1:0] mem [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] clr_data;
  logic              bus_we;
  int_mem_clr_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CLR_VAL(CLR_VAL)) u_seq (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_we(clr_we), .clr_addr(clr_addr),
    .clr_data(clr_data), .init_busy(init_busy), .init_done(init_done)
  );
  // a READY cycle that accepts clr_req does not also service the bus
  assign bus_we = !init_busy && !clr_req && (!we1_n || !we2_n);
  always_ff @(posedge clk) begin
    if (clr_we || bus_we) mem[clr_we ? clr_addr : addr] <= clr_we ? clr_data : data_in;
  end
  if (READ_MODE == 0) begin : g_comb
    assign data_out = init_busy ? CLR_VAL : mem[addr];
  end else begin : g_reg
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data_out <= '0;
      else if (init_busy) data_out <= CLR_VAL;
      else if (!rd_n && !clr_req) data_out <= bus_we ? data_in : mem[addr];
    end
  end
endmodule

// File: doc/int_mem_param.md
# int_mem_param

Parametrised internal data RAM for the 8051 core, the next generation of the 8-bit/256-word internal memory. It has configurable width and depth, selectable combinational or registered read, and a hardware clear sequencer that initialises the array one word per cycle. It can be re-triggered at run time, and it reports busy/done status to the core and the LED controller. It sits between the 8051 core's internal-RAM bus (two write strobes, one read strobe) and any side-band master that needs a known-zero RAM.

## Interface
- DATA_W, 8, data word width in bits
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words
- READ_MODE, 0, 0 = combinational read of mem[addr]; 1 = registered read enabled by rd_n
- CLR_VAL, all-zero DATA_W value, word value written during clear
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- addr  in  ADDR_W  read/write address
- data_in  in  DATA_W  write data
- we1_n  in  1  write strobe 1, active low
- we2_n  in  1  write strobe 2, active low
- rd_n  in  1  read strobe, active low (used only when READ_MODE=1)
- clr_req  in  1  single-cycle request to re-clear the whole array
- data_out  out  DATA_W  read data
- init_busy  out  1  high while clear sequence runs
- init_done  out  1  high once the first clear has completed; cleared only by reset

## Operation
- FSM states: CLEAR, READY. Reset forces CLEAR with clr_ptr = 0.
- CLEAR: each cycle writes CLEAR_VAL to mem[clr_ptr] and increments clr_ptr.
  - At clr_ptr = DEPTH-1, the FSM goes to READY on the same edge; clr_ptr wraps to 0.
- READY: if clr_req = 1, go to CLEAR with clr_ptr = 0. Otherwise service the bus.
- Write: if (!we1_n | !we2_n), then mem[addr] <= data_in. Both strobes low gives one write, with no error.
- Writes during CLEAR are dropped silently.
- clr_req during CLEAR is ignored; the sequence does not restart.
- Read, READ_MODE=0: data_out = mem[addr] combinationally, with no rd_n dependence.
  - During CLEAR, data_out = CLR_VAL.
- Read, READ_MODE=1: on an edge with rd_n = 0 in READY, data_out <= mem[addr]. It holds otherwise.
  - Write-first bypass: if the same edge writes addr, data_out <= data_in.
  - During CLEAR, data_out <= CLR_VAL.
- init_busy = (state == CLEAR).
- init_done sets on the CLEAR→READY transition and stays set through later clr_req cycles.
- Address width is exact: no out-of-range addresses exist, and the array is fully populated.

## Timing
- Reset values:
  - state = CLEAR, clr_ptr = 0
  - init_busy = 1, init_done = 0
  - data_out = 0 (registered mode)
  - Array contents are undefined until clear completes.
- Clear latency is exactly DEPTH rising edges after rst_n deasserts.
  - init_busy falls and init_done rises after edge DEPTH.
  - The first bus write accepted is on edge DEPTH+1.
- Run-time clear: clr_req sampled high on edge N gives init_busy = 1 from N through N+DEPTH. READY resumes after edge N+DEPTH.
- Write latency is 1 edge. In READ_MODE=0, a read of the written address reflects new data immediately after that edge.
- READ_MODE=1 read latency is 1 edge after rd_n sampled low.
- Reset asserted mid-clear or mid-operation takes effect immediately (async). Clear restarts from address 0 on release.

## Structure
- Shared package int_mem_pkg:
  - state enum {CLEAR, READY}
  - default CLR_VAL constant
  - DEPTH derivation function
- Sub-module int_mem_clr_seq holds the FSM, clr_ptr counter, init_busy and init_done. It outputs the clear write enable, address and data.
- The top-level muxes clear vs bus write port and holds the array plus read path.
- Single write port into the array, so it maps to one block RAM write port in registered-read mode.

## Test plan
- Reset release, DEPTH=256: init_busy = 1 for exactly 256 edges, then init_busy = 0 and init_done = 1. Reading all 256 addresses returns 8'h00.
- READY, we1_n = 0, addr = 8'h08, data_in = 8'hA5; then we2_n = 0, addr = 8'h09, data_in = 8'h3C: mem[8] = A5, mem[9] = 3C, verified by readback.
- we1_n = we2_n = 0 at addr 8'h10, data 8'h77: single write, mem[0x10] = 77. Write strobes asserted during CLEAR leave the target at 00.
- READ_MODE=1: rd_n = 0 and we1_n = 0 same edge, addr 8'h20, data 8'h5A: data_out = 5A one edge later (bypass). With rd_n = 1, data_out holds its prior value.
- Fill 0x00–0xFF with their address, pulse clr_req: init_busy 256 edges, init_done stays 1, all words read 00. A second clr_req mid-clear does not extend busy.
- Assert rst_n = 0 at clear step 100: outputs reset asynchronously. After release, clear takes a full 256 edges from address 0.
